msg_tx_serializer: RTL and testbench

//  Transmit-side counterpart of the 10-byte UART message receiver: latches one 80-bit message and

---
 rtl/enigma_uart_pkg.sv | 20 ++
 rtl/msg_tx_serializer.sv | 107 ++++++++++
 tb/tb_msg_tx_serializer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enigma_uart_pkg.sv
// Shared definitions for the Enigma UART message path.
// Holds message geometry, the line-feed terminator and the message FSM state
// encoding used by the transmit serializer (and reusable by a receiver-side FSM).
package enigma_uart_pkg;

    localparam int unsigned MSG_BYTES = 10;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned MSG_W     = MSG_BYTES * BYTE_W;

    localparam logic [BYTE_W-1:0] LF = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GAP,
        DRAIN,
        DONE
    } msg_state_e;

endpackage

// File: rtl/msg_tx_serializer.sv
// Transmit-side message serializer.
// Latches one NBYTES-byte message and hands it to a UART transmitter one byte at a
// time, MSB byte first, so a receiver shifting bytes in at the LSB end rebuilds the
// same word. Optionally appends TERM_BYTE after the payload.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous reset, active-low
//   i_msg      message to send, sampled on an accepted i_msg_stb
//   i_msg_stb  1-cycle send request, accepted only while o_ready=1
//   o_ready    1 while idle and able to accept a message
//   o_done     1-cycle pulse after the last byte's UART frame has completed
//   o_tx_data  byte to UART TX, updated only together with o_tx_stb
//   o_tx_stb   1-cycle strobe to UART TX
//   i_tx_busy  UART TX busy, rises the cycle after o_tx_stb
module msg_tx_serializer
    import enigma_uart_pkg::*;
#(
    parameter int unsigned       NBYTES    = MSG_BYTES,
    parameter bit                TERM_EN   = 1'b0,
    parameter logic [BYTE_W-1:0] TERM_BYTE = LF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BYTE_W*NBYTES-1:0] i_msg,
    input  logic                     i_msg_stb,
    output logic                     o_ready,
    output logic                     o_done,
    output logic [BYTE_W-1:0]        o_tx_data,
    output logic                     o_tx_stb,
    input  logic                     i_tx_busy
);

    localparam int unsigned W     = BYTE_W * NBYTES;
    localparam int unsigned CNT_W = $clog2(NBYTES + 1);

    localparam logic [CNT_W-1:0] TERM_IDX = CNT_W'(NBYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = TERM_EN ? CNT_W'(NBYTES) : CNT_W'(NBYTES - 1);

    msg_state_e        state;
    logic [W-1:0]      shreg;
    logic [CNT_W-1:0]  cnt;
    logic [BYTE_W-1:0] cur_byte;

    // The terminator slot comes after the payload has been shifted out entirely.
    always_comb begin
        cur_byte = shreg[W-1 -: BYTE_W];
        if (TERM_EN && (cnt == TERM_IDX)) begin
            cur_byte = TERM_BYTE;
        end
    end

    assign o_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            o_done    <= 1'b0;
            o_tx_stb  <= 1'b0;
            o_tx_data <= '0;
        end else begin
            o_tx_stb <= 1'b0;
            o_done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_msg_stb) begin
                        shreg <= i_msg;
                        cnt   <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Busy here can be a frame left over from another TX source.
                    if (!i_tx_busy) begin
                        o_tx_stb  <= 1'b1;
                        o_tx_data <= cur_byte;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    // Busy is not yet valid for our own frame; skip one cycle.
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (!i_tx_busy) begin
                        if (cnt == LAST_IDX) begin
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            shreg <= {shreg[W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                            state <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    // o_done is registered on entry, so it is high exactly while in DONE.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msg_tx_serializer.sv
module tb_msg_tx_serializer;
    import enigma_uart_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // Main DUT (no terminator)
    logic [79:0] msg;
    logic        msg_stb;
    logic        ready, done, tx_stb, tx_busy;
    logic [7:0]  tx_data;
    logic        ext_busy;
    int          busy_cnt = 0;
    // Terminator DUT
    logic [79:0] msg_t;
    logic        msg_stb_t;
    logic        ready_t, done_t, tx_stb_t, tx_busy_t;
    logic [7:0]  tx_data_t;
    int          busy_cnt_t = 0;

    msg_tx_serializer dut (
        .clk(clk), .rst(rst), .i_msg(msg), .i_msg_stb(msg_stb), .o_ready(ready),
        .o_done(done), .o_tx_data(tx_data), .o_tx_stb(tx_stb), .i_tx_busy(tx_busy)
    );

    msg_tx_serializer #(.TERM_EN(1'b1)) dut_t (
        .clk(clk), .rst(rst), .i_msg(msg_t), .i_msg_stb(msg_stb_t), .o_ready(ready_t),
        .o_done(done_t), .o_tx_data(tx_data_t), .o_tx_stb(tx_stb_t), .i_tx_busy(tx_busy_t)
    );

    // UART models: busy rises the cycle after stb and lasts 20 cycles.
    assign tx_busy   = ext_busy || (busy_cnt != 0);
    assign tx_busy_t = (busy_cnt_t != 0);
    always @(posedge clk) begin
        if (tx_stb) busy_cnt <= 20;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        if (tx_stb_t) busy_cnt_t <= 20;
        else if (busy_cnt_t != 0) busy_cnt_t <= busy_cnt_t - 1;
    end

    // Monitors
    logic [7:0]  sent[$];
    logic [7:0]  sent_t[$];
    int          done_cnt = 0, done_cnt_t = 0;
    int          stb_viol = 0, stb_viol_t = 0, data_viol = 0;
    logic        stb_prev = 1'b0, stb_prev_t = 1'b0;
    logic [7:0]  data_prev = 8'h00;
    logic        rst_at_edge = 1'b0;
    // Receiver model: shifts each byte in at the LSB end, valid after 10 bytes.
    logic [79:0] rx_word = '0, rx_out = '0;
    int          rx_n = 0, rx_valid_cnt = 0;

    always @(posedge clk) rst_at_edge <= rst;

    always @(negedge clk) begin
        if (!rst_at_edge) begin
            rx_n <= 0;
        end else begin
            if (tx_stb) begin
                sent.push_back(tx_data);
                rx_word <= {rx_word[71:0], tx_data};
                if (rx_n == 9) begin
                    rx_out       <= {rx_word[71:0], tx_data};
                    rx_valid_cnt <= rx_valid_cnt + 1;
                    rx_n         <= 0;
                end else begin
                    rx_n <= rx_n + 1;
                end
            end
            if (!tx_stb && (tx_data !== data_prev)) data_viol <= data_viol + 1;
        end
        if (tx_stb_t) sent_t.push_back(tx_data_t);
        if (tx_stb && stb_prev) stb_viol <= stb_viol + 1;
        if (tx_stb_t && stb_prev_t) stb_viol_t <= stb_viol_t + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (done_t) done_cnt_t <= done_cnt_t + 1;
        stb_prev   <= tx_stb;
        stb_prev_t <= tx_stb_t;
        data_prev  <= tx_data;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start(input logic [79:0] m);
        int i;
        for (i = 0; i < 500; i++) begin
            if (ready === 1'b1) break;
            @(negedge clk);
        end
        if (i == 500) begin
            checks++;
            errors++;
            $display("FAIL start_timeout: ready never rose, expected ready=1");
        end
        msg     = m;
        msg_stb = 1'b1;
        @(negedge clk);
        msg_stb = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        if (i == 2000) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: o_done never pulsed, expected a pulse", name);
        end else begin
            chk({name, "_ready_in_done"}, 80'(ready), 80'(0));
            chk({name, "_busy_at_done"}, 80'(tx_busy), 80'(0));
            @(negedge clk);
            chk({name, "_ready_after_done"}, 80'(ready), 80'(1));
        end
    endtask

    typedef struct {
        logic [79:0] msg;
        logic [7:0]  first;
        logic [7:0]  last;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int base_done, base_valid;
        logic [79:0] m;

        vecs[0] = '{80'h0102030405060708090A, 8'h01, 8'h0A};
        vecs[1] = '{80'hDEADBEEFCAFEF00D1234, 8'hDE, 8'h34};
        vecs[2] = '{80'h80000000000000000001, 8'h80, 8'h01};
        vecs[3] = '{80'hFF00FF00FF00FF00FF00, 8'hFF, 8'h00};

        rst = 1'b0; msg = '0; msg_stb = 1'b0; ext_busy = 1'b0;
        msg_t = '0; msg_stb_t = 1'b0;
        tick(3);
        chk("rst_ready", 80'(ready), 80'(1));
        chk("rst_done", 80'(done), 80'(0));
        chk("rst_stb", 80'(tx_stb), 80'(0));
        chk("rst_data", 80'(tx_data), 80'(0));
        chk("rst_ready_t", 80'(ready_t), 80'(1));
        chk("rst_data_t", 80'(tx_data_t), 80'(0));
        rst = 1'b1;
        tick(2);

        // Tests 1/2: table of messages, full stream and loopback
        for (int v = 0; v < 4; v++) begin
            sent.delete();
            base_done  = done_cnt;
            base_valid = rx_valid_cnt;
            start(vecs[v].msg);
            wait_done($sformatf("vec%0d", v));
            tick(2);
            chk($sformatf("vec%0d_nbytes", v), 80'(sent.size()), 80'(10));
            if (sent.size() == 10) begin
                chk($sformatf("vec%0d_first", v), 80'(sent[0]), 80'(vecs[v].first));
                chk($sformatf("vec%0d_last", v), 80'(sent[9]), 80'(vecs[v].last));
                for (int i = 0; i < 10; i++)
                    chk($sformatf("vec%0d_byte%0d", v, i), 80'(sent[i]),
                        80'(vecs[v].msg[79-8*i -: 8]));
            end
            chk($sformatf("vec%0d_done_cnt", v), 80'(done_cnt - base_done), 80'(1));
            chk($sformatf("vec%0d_rx_word", v), rx_out, vecs[v].msg);
            chk($sformatf("vec%0d_rx_valid", v), 80'(rx_valid_cnt - base_valid), 80'(1));
        end

        // Test 3: stb while busy sending is ignored
        sent.delete();
        base_done = done_cnt;
        start(80'h0102030405060708090A);
        for (int i = 0; i < 1000 && sent.size() < 4; i++) @(negedge clk);
        chk("t3_ready_busy", 80'(ready), 80'(0));
        msg = {80{1'b1}}; msg_stb = 1'b1;
        @(negedge clk);
        msg_stb = 1'b0;
        wait_done("t3");
        tick(60);
        chk("t3_nbytes", 80'(sent.size()), 80'(10));
        if (sent.size() == 10)
            for (int i = 0; i < 10; i++)
                chk($sformatf("t3_byte%0d", i), 80'(sent[i]), 80'(i + 1));
        chk("t3_done_cnt", 80'(done_cnt - base_done), 80'(1));

        // Test 4: reset pulse during the 6th byte
        sent.delete();
        base_done = done_cnt;
        start(80'h11121314151617181920);
        for (int i = 0; i < 1000 && sent.size() < 6; i++) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("t4_stb_after_rst", 80'(tx_stb), 80'(0));
        chk("t4_ready_after_rst", 80'(ready), 80'(1));
        chk("t4_done_after_rst", 80'(done), 80'(0));
        tick(60);
        chk("t4_no_done", 80'(done_cnt - base_done), 80'(0));
        sent.delete();
        base_done  = done_cnt;
        base_valid = rx_valid_cnt;
        m = 80'hA1A2A3A4A5A6A7A8A9AA;
        start(m);
        wait_done("t4b");
        tick(2);
        chk("t4b_nbytes", 80'(sent.size()), 80'(10));
        if (sent.size() == 10) begin
            chk("t4b_first", 80'(sent[0]), 80'(8'hA1));
            chk("t4b_last", 80'(sent[9]), 80'(8'hAA));
        end
        chk("t4b_done_cnt", 80'(done_cnt - base_done), 80'(1));
        chk("t4b_rx_word", rx_out, m);
        chk("t4b_rx_valid", 80'(rx_valid_cnt - base_valid), 80'(1));

        // Test 5: terminator variant
        sent_t.delete();
        msg_t = {10{8'h41}}; msg_stb_t = 1'b1;
        @(negedge clk);
        msg_stb_t = 1'b0;
        begin
            int i;
            for (i = 0; i < 3000; i++) begin
                @(negedge clk);
                if (done_t === 1'b1) break;
            end
            chk("t5_done_seen", 80'(i < 3000), 80'(1));
            chk("t5_busy_at_done", 80'(tx_busy_t), 80'(0));
            chk("t5_nbytes_at_done", 80'(sent_t.size()), 80'(11));
        end
        tick(3);
        chk("t5_nbytes", 80'(sent_t.size()), 80'(11));
        if (sent_t.size() == 11) begin
            for (int i = 0; i < 10; i++)
                chk($sformatf("t5_byte%0d", i), 80'(sent_t[i]), 80'(8'h41));
            chk("t5_term", 80'(sent_t[10]), 80'(8'h0A));
        end
        chk("t5_done_cnt", 80'(done_cnt_t), 80'(1));
        chk("t5_ready", 80'(ready_t), 80'(1));

        // Test 6: external busy at accept, then back-to-back messages
        sent.delete();
        base_done = done_cnt;
        ext_busy  = 1'b1;
        start(80'h3132333435363738393A);
        tick(50);
        chk("t6_no_stb_while_busy", 80'(sent.size()), 80'(0));
        chk("t6_ready_while_busy", 80'(ready), 80'(0));
        ext_busy = 1'b0;
        @(negedge clk);
        chk("t6_first_stb", 80'(tx_stb), 80'(1));
        chk("t6_first_data", 80'(tx_data), 80'(8'h31));
        wait_done("t6a");
        start(80'h4142434445464748494A);
        wait_done("t6b");
        tick(2);
        chk("t6_nbytes", 80'(sent.size()), 80'(20));
        if (sent.size() == 20) begin
            chk("t6_a_last", 80'(sent[9]), 80'(8'h3A));
            chk("t6_b_first", 80'(sent[10]), 80'(8'h41));
            chk("t6_b_last", 80'(sent[19]), 80'(8'h4A));
        end
        chk("t6_done_cnt", 80'(done_cnt - base_done), 80'(2));

        // Protocol invariants observed throughout
        chk("stb_single_cycle", 80'(stb_viol), 80'(0));
        chk("stb_single_cycle_t", 80'(stb_viol_t), 80'(0));
        chk("data_stable_outside_stb", 80'(data_viol), 80'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
